reg_token_queue: RTL
====================

// Module: reg_token_queue
// PURPOSE
//  Latency-insensitive register with a parametrised pending-write queue; generalises the 2-entry token reg.
//  Each accepted write is a token {data,en}; output shows current register value as a token stream.
//  en=0 token re-emits previous value (register-hold semantics); en=1 token updates it.
//  Sits between multi-cycle producers and consumers to absorb DEPTH-1 writes of consumer back-pressure.
// PARAMETERS
//  width  1  data width; 0 = control-only (data ignored, data handshakes forced true)
//  init   0  register value after reset
//  DEPTH  2  total token capacity incl. output slot; legal >=2 (2 = legacy two-entry behaviour)
// PORTS
//  CLK                   in   1             clock, all state on posedge
//  RST                   in   1             synchronous reset, active-high
//  IN_WRITE              in   max(width,1)  write data
//  IN_WRITE_VALID        in   1             write data present
//  IN_WRITE_CONSUMED     out  1             write data taken this cycle
//  IN_EN_WRITE           in   1             write enable carried with token
//  IN_EN_WRITE_VALID     in   1             enable present
//  IN_EN_WRITE_CONSUMED  out  1             enable taken this cycle
//  OUT_READ              out  max(width,1)  current register value
//  OUT_READ_VALID        out  1             output token present
//  OUT_READ_CONSUMED     in   1             consumer takes output token
//  OCCUPANCY             out  clog2(DEPTH+1) tokens held (out slot + queue)
// BEHAVIOUR
//  State: cur (data), cur_v; circular queue Q of DEPTH-1 {data,en}, rd/wr ptrs, cnt.
//  Invariant: cur_v==0 implies cnt==0.
//  inpValid = (width==0 ? 1 : IN_WRITE_VALID) && IN_EN_WRITE_VALID.
//  acc = inpValid && cnt<DEPTH-1; both *_CONSUMED = acc (combinational, same cycle).
//  deq = (width==0 ? 1 : OUT_READ_CONSUMED) && cur_v; deq with cur_v=0 is a no-op.
//  OUT_READ=cur, OUT_READ_VALID=cur_v, OCCUPANCY=cur_v+cnt; all registered-state outputs.
//  Per cycle, "next token" = Q head if cnt>0 else input token if acc:
//   - deq: next token exists -> cur_v<=1, cur<=tok.data iff tok.en; else cur_v<=0.
//   - !deq && !cur_v && acc: input fills cur directly (cur<=IN_WRITE iff IN_EN_WRITE), cur_v<=1.
//   - acc and input not consumed by rules above: push to Q tail, wr ptr wraps at DEPTH-1.
//   - simultaneous pop+push: cnt unchanged, both ptrs advance.
//  Full (cnt==DEPTH-1): acc=0, input stalls; deq same cycle does not free a slot until next cycle.
//  Empty queue + deq + acc: zero-bubble pass-through into cur, latency 1 cycle.
//  Token order strictly FIFO; en=0 tokens never alter cur but still occupy slots.
//  Reset (any cycle, incl. mid-stream): cur<=init, cur_v<=1, cnt<=0, ptrs<=0; queued tokens dropped.
//  Post-reset output: OUT_READ=init, OUT_READ_VALID=1, OCCUPANCY=1, CONSUMED=inpValid.
//  width==0: cur/Q data unused, OUT_READ constant 0, deq true whenever cur_v.
// TESTING
//  Reset: RST=1 two cycles, width=8 init=8'h5A -> OUT_READ=5A, VALID=1, OCCUPANCY=1.
//  Streaming DEPTH=4: write 1,2,3 (en=1) with OUT_READ_CONSUMED=1 each cycle -> OUT_READ 5A,1,2,3; OCC stays 1.
//  Back-pressure DEPTH=4: CONSUMED=0, write 6 tokens -> first 3 accepted, OCC=4, CONSUMED low from 4th; drain order exact.
//  Hold: tokens {7,en=1},{9,en=0},{4,en=1} -> output 7,7,4, three valid beats.
//  Full+simultaneous: cnt=3, deq and write same cycle -> write refused that cycle, accepted next; no loss/dup.
//  Reset mid-stream with OCC=3 -> next cycle OUT_READ=init, OCC=1; old tokens never appear.

Source files
------------

// File: rtl/reg_token_queue_if.sv
// rtl/reg_token_queue_if.sv - write/enable/read token handshakes and occupancy for reg_token_queue
interface reg_token_queue_if #(
  parameter int DW = 1,
  parameter int OW = 2
);
  logic [DW-1:0] in_write;
  logic          in_write_valid;
  logic          in_write_consumed;
  logic          in_en_write;
  logic          in_en_write_valid;
  logic          in_en_write_consumed;
  logic [DW-1:0] out_read;
  logic          out_read_valid;
  logic          out_read_consumed;
  logic [OW-1:0] occupancy;

  modport slave (
    input  in_write, in_write_valid, in_en_write, in_en_write_valid, out_read_consumed,
    output in_write_consumed, in_en_write_consumed, out_read, out_read_valid, occupancy
  );

  modport master (
    output in_write, in_write_valid, in_en_write, in_en_write_valid, out_read_consumed,
    input  in_write_consumed, in_en_write_consumed, out_read, out_read_valid, occupancy
  );
endinterface

// File: rtl/reg_token_queue.sv
// rtl/reg_token_queue.sv - latency-insensitive register with a DEPTH-token pending-write queue
module reg_token_queue #(
  parameter int          width = 1,
  parameter logic [63:0] init  = '0,
  parameter int          DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  reg_token_queue_if.slave    bus
);
  localparam int DW = (width == 0) ? 1 : width;
  localparam int QD = DEPTH - 1;
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] INIT_V = (width == 0) ? '0 : init[DW-1:0];

  logic [DW-1:0] cur_q, cur_d;
  logic          cur_v_q, cur_v_d;
  logic [DW-1:0] qdata_q [QD];
  logic          qen_q   [QD];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0] cnt_q, cnt_d;

  logic          inp_valid, acc, deq, taken, push, pop;
  logic [DW-1:0] in_data;

  assign inp_valid = ((width == 0) ? 1'b1 : bus.in_write_valid) && bus.in_en_write_valid;
  assign acc       = inp_valid && (cnt_q < OW'(QD));
  assign deq       = ((width == 0) ? 1'b1 : bus.out_read_consumed) && cur_v_q;
  assign in_data   = (width == 0) ? '0 : bus.in_write;

  assign bus.in_write_consumed    = acc;
  assign bus.in_en_write_consumed = acc;
  assign bus.out_read             = cur_q;
  assign bus.out_read_valid       = cur_v_q;
  assign bus.occupancy            = OW'(cur_v_q) + cnt_q;

  // Queue head has priority over the live input so tokens leave in strict FIFO order.
  always_comb begin
    cur_d   = cur_q;
    cur_v_d = cur_v_q;
    taken   = 1'b0;
    pop     = 1'b0;
    if (deq) begin
      if (cnt_q != '0) begin
        pop     = 1'b1;
        cur_v_d = 1'b1;
        if (qen_q[rd_q]) cur_d = qdata_q[rd_q];
      end else if (acc) begin
        taken   = 1'b1;
        cur_v_d = 1'b1;
        if (bus.in_en_write) cur_d = in_data;
      end else begin
        cur_v_d = 1'b0;
      end
    end else if (!cur_v_q && acc) begin
      taken   = 1'b1;
      cur_v_d = 1'b1;
      if (bus.in_en_write) cur_d = in_data;
    end
    push = acc && !taken;

    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop)  rd_d = (rd_q == PW'(QD - 1)) ? '0 : rd_q + 1'b1;
    if (push) wr_d = (wr_q == PW'(QD - 1)) ? '0 : wr_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q   <= INIT_V;
      cur_v_q <= 1'b1;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      cur_q   <= cur_d;
      cur_v_q <= cur_v_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot contents need no reset: cnt gates every read.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      qdata_q[wr_q] <= in_data;
      qen_q[wr_q]   <= bus.in_en_write;
    end
  end
endmodule
